timer_counter: RTL and testbench

TIMER_COUNTER -- requirements
Module: timer_counter

---
 rtl/timer_counter_pkg.sv | 41 ++++
 rtl/timer_counter.sv | 123 ++++++++++++
 tb/tb_timer_counter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_counter_pkg.sv
// Shared constants for the bus timer: register offsets, mode codes,
// FSM state encodings and the bridge address windows of TC0/TC1.
package timer_counter_pkg;

    localparam int unsigned DATA_W = 32;

    // Word offsets as decoded from Addr[3:2]
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;

    localparam int unsigned CTRL_EN  = 0;
    localparam int unsigned CTRL_IM  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tc_state_t;

    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } tc_ctrl_t;

    localparam logic [31:0] TC0_ADDR_BEGIN = 32'h0000_7F00;
    localparam logic [31:0] TC0_ADDR_END   = 32'h0000_7F0B;
    localparam logic [31:0] TC1_ADDR_BEGIN = 32'h0000_7F10;
    localparam logic [31:0] TC1_ADDR_END   = 32'h0000_7F1B;

    function automatic logic is_periodic(input tc_ctrl_t c);
        return c.mode == MODE_PERIODIC;
    endfunction

endpackage

// File: rtl/timer_counter.sv
// Bus-mapped down-counting timer with one-shot and periodic modes.
// One instance per timer; the bridge selects TC0/TC1 via WE qualification.
module timer_counter
    import timer_counter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    tc_state_t   state_q;
    tc_state_t   state_d;
    tc_ctrl_t    ctrl_q;
    tc_ctrl_t    ctrl_d;
    logic [31:0] preset_q;
    logic [31:0] preset_d;
    logic [31:0] count_q;
    logic [31:0] count_d;
    logic        irq_q;
    logic        irq_d;
    logic        en_clr;

    logic [1:0]  sel;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        unused_addr;

    assign sel         = Addr[3:2];
    assign wr_ctrl     = WE && (sel == OFF_CTRL);
    assign wr_preset   = WE && (sel == OFF_PRESET);
    assign unused_addr = ^{Addr[31:4], Addr[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        irq_d   = irq_q;
        en_clr  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ctrl_q.en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q.en) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d = '0;
                    irq_d   = 1'b1;
                    state_d = ST_INT;
                end
            end
            ST_INT: begin
                // Periodic returns through IDLE, which reloads while EN holds
                if (is_periodic(ctrl_q)) begin
                    irq_d = 1'b0;
                end else begin
                    en_clr = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (wr_ctrl || wr_preset) begin
            irq_d = 1'b0;
        end
    end

    // A CTRL write lands after the one-shot EN clear so software wins
    always_comb begin
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        if (en_clr) begin
            ctrl_d.en = 1'b0;
        end
        if (wr_ctrl) begin
            ctrl_d = tc_ctrl_t'(Din[3:0]);
        end
        if (wr_preset) begin
            preset_d = Din;
        end
    end

    always_comb begin
        Dout = '0;
        unique case (sel)
            OFF_CTRL:   Dout = {28'b0, ctrl_q};
            OFF_PRESET: Dout = preset_q;
            OFF_COUNT:  Dout = count_q;
            OFF_RSVD:   Dout = '0;
            default:    Dout = '0;
        endcase
    end

    assign IRQ = irq_q && ctrl_q.im;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter with a timeline-based reference model
// compared against the DUT every cycle, plus literal spot checks.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int errors = 0;
    int checks = 0;
    bit chk_on = 0;

    localparam logic [31:0] A_CTRL = 32'h0000_7F00;
    localparam logic [31:0] A_PRE  = 32'h0000_7F04;
    localparam logic [31:0] A_CNT  = 32'h0000_7F08;
    localparam logic [31:0] A_RSV  = 32'h0000_7F0C;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: "age" counts edges since the timer was seen idle with EN=1.
    // age 1 latches PRESET, interrupt fires at age max(N,1)+2, and the
    // edge after that ends the run (periodic restarts from age 0).
    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] preset;
        logic [31:0] count;
        logic [31:0] n;
        logic        irq;
        longint      age;
        longint      int_age;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t step(mdl_t s, logic we, logic [31:0] a,
                                  logic [31:0] d);
        mdl_t r;
        r = s;
        if (s.age == 0) begin
            if (s.ctrl[0]) r.age = 1;
        end else if (s.age == 1) begin
            r.n       = s.preset;
            r.count   = s.preset;
            r.int_age = (s.preset <= 1) ? 3 : longint'(s.preset) + 2;
            r.age     = 2;
        end else if (s.age < s.int_age) begin
            if (!s.ctrl[0]) begin
                r.age = 0;
            end else begin
                r.age = s.age + 1;
                if (r.age == s.int_age) begin
                    r.count = '0;
                    r.irq   = 1'b1;
                end else begin
                    r.count = s.n - 32'(r.age - 2);
                end
            end
        end else begin
            if (s.ctrl[2:1] == 2'b01) r.irq = 1'b0;
            else r.ctrl[0] = 1'b0;
            r.age = 0;
        end
        if (we && a[3:2] == 2'd0) begin
            r.ctrl = d[3:0];
            r.irq  = 1'b0;
        end
        if (we && a[3:2] == 2'd1) begin
            r.preset = d;
            r.irq    = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [31:0] mread(mdl_t s, logic [31:0] a);
        case (a[3:2])
            2'd0:    return {28'b0, s.ctrl};
            2'd1:    return s.preset;
            2'd2:    return s.count;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= '{default: 0};
        else m <= step(m, WE, Addr, Din);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_irq", {31'b0, IRQ}, {31'b0, m.irq & m.ctrl[3]});
            chk("model_dout", Dout, mread(m, Addr));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Addr = a;
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a,
                          input logic [31:0] exp);
        Addr = a;
        #1;
        chk(name, Dout, exp);
    endtask

    initial begin
        reset = 1'b1;
        WE    = 1'b0;
        Addr  = A_CTRL;
        Din   = '0;
        #1 reset = 1'b0;
        #1;
        chk("rst_irq", {31'b0, IRQ}, 32'd0);
        for (int i = 0; i < 4; i++)
            rd_chk("rst_dout", A_CTRL + 32'(i * 4), 32'd0);
        #14 reset = 1'b1;
        chk_on = 1;
        @(posedge clk);
        #1;

        // One-shot, N=3: interrupt at edge 5
        wr(A_PRE, 32'd3);
        wr(A_CTRL, 32'h9);
        tick(4);
        chk("os_irq_e4", {31'b0, IRQ}, 32'd0);
        tick(1);
        chk("os_irq_e5", {31'b0, IRQ}, 32'd1);
        rd_chk("os_count", A_CNT, 32'd0);
        tick(1);
        rd_chk("os_ctrl", A_CTRL, 32'h8);
        tick(3);
        chk("os_irq_hold", {31'b0, IRQ}, 32'd1);
        wr(A_CTRL, 32'h0);
        chk("os_irq_clr", {31'b0, IRQ}, 32'd0);

        // Periodic, N=2: pulses every 5 cycles
        wr(A_PRE, 32'd2);
        wr(A_CTRL, 32'hB);
        Addr = A_CNT;
        for (int e = 1; e <= 15; e++) begin
            tick(1);
            chk("per_irq", {31'b0, IRQ}, {31'b0, (e % 5) == 4});
            chk("per_count", Dout,
                (e % 5 == 2) ? 32'd2 : (e % 5 == 3) ? 32'd1 : 32'd0);
        end
        wr(A_CTRL, 32'h0);
        tick(3);

        // Masked
        wr(A_PRE, 32'd2);
        wr(A_CTRL, 32'h1);
        tick(6);
        rd_chk("mask_count", A_CNT, 32'd0);
        chk("mask_irq", {31'b0, IRQ}, 32'd0);
        rd_chk("mask_ctrl", A_CTRL, 32'h0);
        wr(A_CTRL, 32'h8);
        chk("mask_irq_im", {31'b0, IRQ}, 32'd0);
        rd_chk("mask_ctrl8", A_CTRL, 32'h8);
        wr(A_CTRL, 32'h0);

        // Disable mid-count at COUNT=6
        wr(A_PRE, 32'd10);
        wr(A_CTRL, 32'h1);
        tick(5);
        rd_chk("dis_count7", A_CNT, 32'd7);
        wr(A_CTRL, 32'h0);
        tick(3);
        rd_chk("dis_count6", A_CNT, 32'd6);
        chk("dis_irq", {31'b0, IRQ}, 32'd0);

        // CTRL write in INT beats the one-shot EN clear
        wr(A_PRE, 32'd1);
        wr(A_CTRL, 32'h9);
        tick(3);
        chk("win_irq", {31'b0, IRQ}, 32'd1);
        wr(A_CTRL, 32'h9);
        rd_chk("win_ctrl", A_CTRL, 32'h9);
        chk("win_irq_clr", {31'b0, IRQ}, 32'd0);
        wr(A_CTRL, 32'h0);
        tick(3);

        // Boundary: PRESET=0, ignored writes, reserved read
        wr(A_PRE, 32'd0);
        wr(A_CTRL, 32'h9);
        tick(2);
        chk("b0_irq_e2", {31'b0, IRQ}, 32'd0);
        tick(1);
        chk("b0_irq_e3", {31'b0, IRQ}, 32'd1);
        wr(A_CNT, 32'd5);
        rd_chk("b0_count", A_CNT, 32'd0);
        chk("b0_irq_keep", {31'b0, IRQ}, 32'd1);
        wr(A_RSV, 32'h1234_5678);
        rd_chk("b0_rsv", A_RSV, 32'd0);
        rd_chk("b0_pre", A_PRE, 32'd0);
        wr(A_CTRL, 32'hFFFF_FFF0);
        rd_chk("b0_ctrl_mask", A_CTRL, 32'h0);
        wr(A_PRE, 32'hDEAD_BEEF);
        rd_chk("b0_pre_full", A_PRE, 32'hDEAD_BEEF);
        rd_chk("b0_alias", 32'hFFFF_FFF4, 32'hDEAD_BEEF);

        // PRESET write during CNT only affects the next load
        wr(A_PRE, 32'd5);
        wr(A_CTRL, 32'h3);
        tick(3);
        wr(A_PRE, 32'd2);
        rd_chk("pre_cnt", A_CNT, 32'd3);
        tick(6);
        rd_chk("pre_reload", A_CNT, 32'd2);
        wr(A_CTRL, 32'h0);
        tick(3);

        // Reset in periodic mode at COUNT=4
        wr(A_PRE, 32'd6);
        wr(A_CTRL, 32'hB);
        tick(4);
        rd_chk("rs_count4", A_CNT, 32'd4);
        reset = 1'b0;
        #1;
        chk("rs_irq", {31'b0, IRQ}, 32'd0);
        for (int i = 0; i < 4; i++)
            rd_chk("rs_dout", A_CTRL + 32'(i * 4), 32'd0);
        @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        tick(5);
        rd_chk("rs_idle", A_CNT, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
